// File: rtl/fp_mult_bist.sv
// fp_mult_bist -- built-in self-test engine for the pipelined FP multiplier.
//
// Drives pseudo-random operands a/b from two Galois LFSRs and steps the
// rounding mode rnd through 0..NUM_MODES-1, issuing VECS_PER_MODE vectors per
// mode (one per cycle).  Results returning LATENCY cycles later are folded
// into a 32-bit MISR.  Once done=1, signature is compared against a golden
// value.
//
// Optional build macro: BIST_STATUS_MISR_EN
//    defined   -> compaction term is z ^ {24'b0, status}
//    undefined -> status is ignored and only z is compacted
//
// Ports:
//    clk        in   1   clock
//    rst        in   1   synchronous active-high reset
//    start      in   1   start a run (honoured only in IDLE or DONE)
//    a, b       out  32  operands to the multiplier
//    rnd        out  3   rounding mode to the multiplier
//    z          in   32  multiplier result
//    status     in   8   multiplier status flags
//    busy       out  1   high while issuing (RUN) or draining (DRAIN)
//    done       out  1   high in DONE until the next start or rst
//    signature  out  32  MISR contents, final once done=1
//    vec_cnt    out  8   vectors issued in the current run
module fp_mult_bist #(
   parameter int          LATENCY       = 2,
   parameter int          VECS_PER_MODE = 10,
   parameter int          NUM_MODES     = 6,
   parameter logic [31:0] SEED_A        = 32'h0000_0001,
   parameter logic [31:0] SEED_B        = 32'h0000_ACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [31:0] a,
   output logic [31:0] b,
   output logic [2:0]  rnd,
   input  logic [31:0] z,
   input  logic [7:0]  status,
   output logic        busy,
   output logic        done,
   output logic [31:0] signature,
   output logic [7:0]  vec_cnt
);

   localparam int          TOTAL      = VECS_PER_MODE * NUM_MODES;
   localparam logic [7:0]  LAST_CNT   = 8'(TOTAL - 1);
   localparam logic [7:0]  TOTAL_CNT  = 8'(TOTAL);
   localparam logic [7:0]  MODE_LAST  = 8'(VECS_PER_MODE - 1);
   localparam logic [7:0]  DRAIN_LAST = 8'(LATENCY - 1);
   localparam logic [31:0] POLY       = 32'h0040_0007;
   localparam logic [31:0] SIG_INIT   = 32'hFFFF_FFFF;

   // Galois step for x^32+x^22+x^2+x+1, shared by operand LFSRs and the MISR.
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0);
   endfunction

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t              state_reg;
   logic [7:0]          mode_vec_reg;   // position inside the current rounding mode
   logic [7:0]          drain_cnt_reg;
   logic [LATENCY-1:0]  valid_reg;      // issue-valid pipe, aligned with z
   logic [LATENCY-1:0]  valid_next;
   logic [31:0]         comp_term;
   logic                start_ok;

   assign start_ok = start && (state_reg == IDLE || state_reg == DONE);

   // The multiplier samples a/b/rnd on every RUN-ending edge, so a RUN cycle
   // is exactly one issued vector.
   assign valid_next[0] = (state_reg == RUN);
   generate
      for (genvar gi = 1; gi < LATENCY; gi++) begin : g_valid
         assign valid_next[gi] = valid_reg[gi-1];
      end
   endgenerate

`ifdef BIST_STATUS_MISR_EN
   assign comp_term = z ^ {24'b0, status};
`else
   logic status_unused;
   assign status_unused = ^status;
   assign comp_term     = z;
`endif

   always_ff @(posedge clk) begin
      if (rst || start_ok) begin
         valid_reg <= '0;
      end else begin
         valid_reg <= valid_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         a             <= 32'h0;
         b             <= 32'h0;
         rnd           <= 3'd0;
         busy          <= 1'b0;
         done          <= 1'b0;
         signature     <= SIG_INIT;
         vec_cnt       <= 8'd0;
         mode_vec_reg  <= 8'd0;
         drain_cnt_reg <= 8'd0;
      end else begin
         // Tail of the valid pipe marks the cycle whose z belongs to an issued vector.
         if (valid_reg[LATENCY-1]) begin
            signature <= lfsr_step(signature) ^ comp_term;
         end
         case (state_reg)
            IDLE, DONE: begin
               if (start) begin
                  state_reg     <= RUN;
                  a             <= SEED_A;
                  b             <= SEED_B;
                  rnd           <= 3'd0;
                  signature     <= SIG_INIT;
                  vec_cnt       <= 8'd0;
                  mode_vec_reg  <= 8'd0;
                  drain_cnt_reg <= 8'd0;
                  busy          <= 1'b1;
                  done          <= 1'b0;
               end
            end
            RUN: begin
               if (vec_cnt != TOTAL_CNT) begin
                  vec_cnt <= vec_cnt + 8'd1;
               end
               if (vec_cnt == LAST_CNT) begin
                  // Last vector is being issued: hold it on the outputs while draining.
                  state_reg <= DRAIN;
               end else begin
                  a <= lfsr_step(a);
                  b <= lfsr_step(b);
                  if (mode_vec_reg == MODE_LAST) begin
                     mode_vec_reg <= 8'd0;
                     rnd          <= rnd + 3'd1;
                  end else begin
                     mode_vec_reg <= mode_vec_reg + 8'd1;
                  end
               end
            end
            DRAIN: begin
               if (drain_cnt_reg == DRAIN_LAST) begin
                  state_reg <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
               end else begin
                  drain_cnt_reg <= drain_cnt_reg + 8'd1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_mult_bist.sv
// Testbench for fp_mult_bist: a two-stage multiplier stand-in answers the
// engine's vectors, and a vector-list reference model predicts operands,
// rounding modes and the final MISR signature for each run.
module tb_fp_mult_bist;

   localparam int          LATENCY = 2;
   localparam int          VPM     = 10;
   localparam int          NMODES  = 6;
   localparam int          TOTAL   = VPM * NMODES;
   localparam logic [31:0] SEED_A  = 32'h0000_0001;
   localparam logic [31:0] SEED_B  = 32'h0000_ACE1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] a, b, z, signature;
   logic [2:0]  rnd;
   logic [7:0]  status, vec_cnt;
   logic        busy, done;

   int checks = 0;
   int failures = 0;

   // stand-in multiplier controls
   logic [31:0] salt = 32'h0;
   int          inj_vec = 0;
   int          inj_bit = 0;
   int          st_vec = 0;
   logic [7:0]  st_val = 8'h0;
   logic [31:0] stage_z;
   logic [7:0]  stage_s;

   logic [31:0] exp_a [1:TOTAL];
   logic [31:0] exp_b [1:TOTAL];
   logic [2:0]  exp_r [1:TOTAL];
   logic [31:0] golden;
   logic [31:0] exp_sig;

   fp_mult_bist #(
      .LATENCY(LATENCY), .VECS_PER_MODE(VPM), .NUM_MODES(NMODES),
      .SEED_A(SEED_A), .SEED_B(SEED_B)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .rnd(rnd),
      .z(z), .status(status), .busy(busy), .done(done),
      .signature(signature), .vec_cnt(vec_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] step(input logic [31:0] s);
      return {s[30:0], 1'b0} ^ (s[31] ? 32'h0040_0007 : 32'h0);
   endfunction

   function automatic logic [31:0] mult_fn(input logic [31:0] x, input logic [31:0] y,
                                           input logic [2:0] r);
      logic [31:0] p;
      p = x * y;
      return p ^ {29'b0, r} ^ salt;
   endfunction

   // Two register stages: vector sampled at edge k, z valid after edge k+1.
   // Faults are injected by vector number (vector presented = vec_cnt+1).
   always @(posedge clk) begin
      stage_z <= mult_fn(a, b, rnd) ^
                 ((busy && (int'(vec_cnt) + 1 == inj_vec)) ? (32'h1 << inj_bit) : 32'h0);
      stage_s <= (busy && (int'(vec_cnt) + 1 == st_vec)) ? st_val : 8'h0;
      z       <= stage_z;
      status  <= stage_s;
   end

   // Reference: fold the expected result of every vector 1..TOTAL in order.
   function automatic logic [31:0] model_sig(input int iv, input int ib,
                                             input int sv, input logic [7:0] sval);
      logic [31:0] sig, zz;
      sig = 32'hFFFF_FFFF;
      for (int k = 1; k <= TOTAL; k++) begin
         zz = mult_fn(exp_a[k], exp_b[k], exp_r[k]);
         if (k == iv) zz = zz ^ (32'h1 << ib);
`ifdef BIST_STATUS_MISR_EN
         if (k == sv) zz = zz ^ {24'b0, sval};
`else
         if (k == sv && sval != 8'h0) zz = zz ^ 32'h0;
`endif
         sig = step(sig) ^ zz;
      end
      return sig;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_a"}, a, 32'h0);
      check({tag, "_b"}, b, 32'h0);
      check({tag, "_rnd"}, {29'b0, rnd}, 32'h0);
      check({tag, "_busy"}, {31'b0, busy}, 32'h0);
      check({tag, "_done"}, {31'b0, done}, 32'h0);
      check({tag, "_sig"}, signature, 32'hFFFF_FFFF);
      check({tag, "_vec_cnt"}, {24'b0, vec_cnt}, 32'h0);
   endtask

   // One full run: start pulse, then one sample per negedge until done.
   task automatic do_run(input string tag, input logic [31:0] expect_sig,
                         input bit chk_vec, input bit chatter);
      int busy_cycles;
      int done_cycle;
      busy_cycles = 0;
      done_cycle  = 0;
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (done) begin
            start      = 1'b0;
            done_cycle = c;
            break;
         end
         if (busy) begin
            busy_cycles++;
            if (chk_vec && c <= TOTAL) begin
               check($sformatf("%s_a_v%0d", tag, c), a, exp_a[c]);
               check($sformatf("%s_b_v%0d", tag, c), b, exp_b[c]);
               check($sformatf("%s_rnd_v%0d", tag, c), {29'b0, rnd}, {29'b0, exp_r[c]});
            end
            start = chatter ? 1'($urandom_range(0, 1)) : 1'b0;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      check({tag, "_done_cycle"}, done_cycle, 63);
      check({tag, "_busy_cycles"}, busy_cycles, 62);
      check({tag, "_busy_at_done"}, {31'b0, busy}, 32'h0);
      check({tag, "_vec_cnt"}, {24'b0, vec_cnt}, TOTAL);
      check({tag, "_rnd_final"}, {29'b0, rnd}, NMODES - 1);
      check({tag, "_a_hold"}, a, exp_a[TOTAL]);
      check({tag, "_sig"}, signature, expect_sig);
      $display("run %s: done_cycle=%0d busy_cycles=%0d vec_cnt=%0d signature=0x%08h expected=0x%08h",
               tag, done_cycle, busy_cycles, vec_cnt, signature, expect_sig);
   endtask

   initial begin
      logic [31:0] sa, sb;
      salt = $urandom;
      sa = SEED_A;
      sb = SEED_B;
      for (int k = 1; k <= TOTAL; k++) begin
         exp_a[k] = sa;
         exp_b[k] = sb;
         exp_r[k] = 3'((k - 1) / VPM);
         sa = step(sa);
         sb = step(sb);
      end
      golden = model_sig(0, 0, 0, 8'h0);

      // reset held for three cycles
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;
      @(negedge clk);
      check("idle_done_low", {31'b0, done}, 32'h0);

      // clean run with per-vector operand/mode checks
      do_run("clean", golden, 1'b1, 1'b0);
      check("rnd_at_v11", {29'b0, exp_r[11]}, 32'd1);
      check("rnd_at_v51", {29'b0, exp_r[51]}, 32'd5);

      // z bit flip on vector 37 only
      inj_vec = 37;
      inj_bit = $urandom_range(0, 31);
      exp_sig = model_sig(37, inj_bit, 0, 8'h0);
      do_run("inject37", exp_sig, 1'b0, 1'b0);
      check("inject37_differs", {31'b0, signature != golden}, 32'h1);
      inj_vec = 0;

      // clean restart from DONE reproduces the golden signature
      do_run("rerun", golden, 1'b0, 1'b0);

      // reset in the middle of a run, then a fresh run with start chatter
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (vec_cnt == 8'd20) break;
         @(negedge clk);
      end
      check("midrun_reached_v20", {24'b0, vec_cnt}, 32'd20);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_state("midrun_reset");
      do_run("after_reset_chatter", golden, 1'b1, 1'b1);

      // status flag on a single vector
      st_vec  = $urandom_range(1, TOTAL);
      st_val  = 8'h01;
      exp_sig = model_sig(0, 0, st_vec, 8'h01);
      do_run("status_flag", exp_sig, 1'b0, 1'b0);
      st_vec  = 0;
      st_val  = 8'h0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
